// File: rtl/mdio_slave.sv
// Clause-22 MDIO responder: recovers MDC/MDIO frames and maps them onto a 32x16 register-file port.
// Optional feature: define MDIO_PREAMBLE_SUPPRESS_EN to accept ST after a single preamble 1.
module mdio_slave #(
    parameter int PRE_MIN = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mdc_i,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_oe,
    input  logic [4:0]  phy_addr,
    output logic [4:0]  reg_addr,
    output logic        reg_rd,
    input  logic [15:0] reg_rdata,
    output logic        reg_wr,
    output logic [15:0] reg_wdata,
    output logic        busy,
    output logic        frame_err
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0] PRE_TGT = 6'd1;
`else
    localparam logic [5:0] PRE_TGT = 6'(PRE_MIN);
`endif

    typedef enum logic [2:0] {
        S_PRE  = 3'd0,
        S_ST   = 3'd1,
        S_HDR  = 3'd2,
        S_TA   = 3'd3,
        S_DATA = 3'd4,
        S_SKIP = 3'd5
    } state_t;

    logic        mdc_meta_r, mdc_sync1_r, mdc_sync2_r;
    logic        mdio_meta_r, mdio_sync1_r;
    logic        sample_s, bit_s;

    state_t      state_r, state_s;
    logic [5:0]  pre_cnt_r, pre_cnt_s;
    logic [4:0]  bit_k_r, bit_k_s;
    logic [10:0] hdr_r, hdr_s;
    logic [11:0] hdr_shift_s;
    logic [14:0] wsh_r, wsh_s;
    logic [15:0] rdata_r, rdata_s;
    logic [3:0]  rd_idx_s;
    logic        is_read_r, is_read_s;
    logic        mdio_o_r, mdio_o_s;
    logic        mdio_oe_r, mdio_oe_s;
    logic [4:0]  reg_addr_r, reg_addr_s;
    logic        reg_rd_r, reg_rd_s;
    logic        reg_wr_r, reg_wr_s;
    logic [15:0] reg_wdata_r, reg_wdata_s;
    logic        busy_r, busy_s;
    logic        frame_err_r, frame_err_s;

    // Two-flop synchronizer for MDC and MDIO plus one extra MDC stage for edge detection.
    always_ff @(posedge clk) begin
        mdc_meta_r   <= mdc_i;
        mdc_sync1_r  <= mdc_meta_r;
        mdc_sync2_r  <= mdc_sync1_r;
        mdio_meta_r  <= mdio_i;
        mdio_sync1_r <= mdio_meta_r;
    end

    assign sample_s    = mdc_sync1_r & ~mdc_sync2_r;
    assign bit_s       = mdio_sync1_r;
    assign hdr_shift_s = {hdr_r, bit_s};
    // (30 - k) mod 16 selects rdata bit 15 at k=15 down to bit 0 at k=30
    assign rd_idx_s    = 4'd14 - bit_k_r[3:0];

    // Next-state and next-output logic, advancing only on the MDC sample event.
    always_comb begin
        state_s     = state_r;
        pre_cnt_s   = pre_cnt_r;
        bit_k_s     = bit_k_r;
        hdr_s       = hdr_r;
        wsh_s       = wsh_r;
        is_read_s   = is_read_r;
        mdio_o_s    = mdio_o_r;
        mdio_oe_s   = mdio_oe_r;
        reg_addr_s  = reg_addr_r;
        reg_wdata_s = reg_wdata_r;
        busy_s      = busy_r;
        reg_rd_s    = 1'b0;
        reg_wr_s    = 1'b0;
        frame_err_s = 1'b0;

        if (reg_rd_r) begin
            rdata_s = reg_rdata;
        end else begin
            rdata_s = rdata_r;
        end

        if (sample_s) begin
            case (state_r)
                S_PRE: begin
                    if (bit_s) begin
                        if (pre_cnt_r != PRE_TGT) begin
                            pre_cnt_s = pre_cnt_r + 6'd1;
                        end else begin
                            pre_cnt_s = pre_cnt_r;
                        end
                    end else if (pre_cnt_r == PRE_TGT) begin
                        state_s   = S_ST;
                        bit_k_s   = 5'd1;
                        busy_s    = 1'b1;
                        pre_cnt_s = 6'd0;
                    end else begin
                        pre_cnt_s = 6'd0;
                    end
                end
                S_ST: begin
                    if (bit_s) begin
                        state_s = S_HDR;
                        bit_k_s = 5'd2;
                    end else begin
                        frame_err_s = 1'b1;
                        state_s     = S_PRE;
                        pre_cnt_s   = 6'd0;
                        busy_s      = 1'b0;
                        bit_k_s     = 5'd0;
                    end
                end
                S_HDR: begin
                    hdr_s   = hdr_shift_s[10:0];
                    bit_k_s = bit_k_r + 5'd1;
                    if ((bit_k_r == 5'd3) &&
                        ((hdr_shift_s[1:0] == 2'b00) || (hdr_shift_s[1:0] == 2'b11))) begin
                        frame_err_s = 1'b1;
                        state_s     = S_PRE;
                        pre_cnt_s   = 6'd0;
                        busy_s      = 1'b0;
                        bit_k_s     = 5'd0;
                    end else if (bit_k_r == 5'd13) begin
                        // hdr_shift_s = {OP[1:0], PHYAD[4:0], REGAD[4:0]}
                        if (hdr_shift_s[9:5] != phy_addr) begin
                            state_s = S_SKIP;
                        end else begin
                            state_s    = S_TA;
                            reg_addr_s = hdr_shift_s[4:0];
                            is_read_s  = (hdr_shift_s[11:10] == 2'b10);
                            reg_rd_s   = (hdr_shift_s[11:10] == 2'b10);
                        end
                    end else begin
                        state_s = S_HDR;
                    end
                end
                S_TA: begin
                    bit_k_s = bit_k_r + 5'd1;
                    if (is_read_r) begin
                        if (bit_k_r == 5'd14) begin
                            mdio_oe_s = 1'b1;
                            mdio_o_s  = 1'b0;
                        end else begin
                            mdio_o_s  = rdata_r[rd_idx_s];
                        end
                    end else begin
                        mdio_oe_s = 1'b0;
                    end
                    if (bit_k_r == 5'd15) begin
                        state_s = S_DATA;
                    end else begin
                        state_s = S_TA;
                    end
                end
                S_DATA: begin
                    wsh_s = {wsh_r[13:0], bit_s};
                    if (bit_k_r == 5'd31) begin
                        state_s   = S_PRE;
                        pre_cnt_s = 6'd0;
                        busy_s    = 1'b0;
                        bit_k_s   = 5'd0;
                        mdio_oe_s = 1'b0;
                        mdio_o_s  = 1'b1;
                        if (is_read_r) begin
                            reg_wr_s = 1'b0;
                        end else begin
                            reg_wr_s    = 1'b1;
                            reg_wdata_s = {wsh_r, bit_s};
                        end
                    end else begin
                        bit_k_s = bit_k_r + 5'd1;
                        if (is_read_r) begin
                            mdio_o_s = rdata_r[rd_idx_s];
                        end else begin
                            mdio_o_s = mdio_o_r;
                        end
                    end
                end
                S_SKIP: begin
                    if (bit_k_r == 5'd31) begin
                        state_s   = S_PRE;
                        pre_cnt_s = 6'd0;
                        busy_s    = 1'b0;
                        bit_k_s   = 5'd0;
                    end else begin
                        bit_k_s = bit_k_r + 5'd1;
                    end
                end
                default: begin
                    state_s   = S_PRE;
                    pre_cnt_s = 6'd0;
                    busy_s    = 1'b0;
                    bit_k_s   = 5'd0;
                    mdio_oe_s = 1'b0;
                    mdio_o_s  = 1'b1;
                end
            endcase
        end else begin
            state_s = state_r;
        end
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_PRE;
            pre_cnt_r   <= 6'd0;
            bit_k_r     <= 5'd0;
            hdr_r       <= 11'd0;
            wsh_r       <= 15'd0;
            rdata_r     <= 16'd0;
            is_read_r   <= 1'b0;
            mdio_o_r    <= 1'b1;
            mdio_oe_r   <= 1'b0;
            reg_addr_r  <= 5'd0;
            reg_rd_r    <= 1'b0;
            reg_wr_r    <= 1'b0;
            reg_wdata_r <= 16'd0;
            busy_r      <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            state_r     <= state_s;
            pre_cnt_r   <= pre_cnt_s;
            bit_k_r     <= bit_k_s;
            hdr_r       <= hdr_s;
            wsh_r       <= wsh_s;
            rdata_r     <= rdata_s;
            is_read_r   <= is_read_s;
            mdio_o_r    <= mdio_o_s;
            mdio_oe_r   <= mdio_oe_s;
            reg_addr_r  <= reg_addr_s;
            reg_rd_r    <= reg_rd_s;
            reg_wr_r    <= reg_wr_s;
            reg_wdata_r <= reg_wdata_s;
            busy_r      <= busy_s;
            frame_err_r <= frame_err_s;
        end
    end

    assign mdio_o    = mdio_o_r;
    assign mdio_oe   = mdio_oe_r;
    assign reg_addr  = reg_addr_r;
    assign reg_rd    = reg_rd_r;
    assign reg_wr    = reg_wr_r;
    assign reg_wdata = reg_wdata_r;
    assign busy      = busy_r;
    assign frame_err = frame_err_r;

endmodule

// File: tb/tb_mdio_slave.sv
// Scoreboard bench for mdio_slave: the bench acts as MDIO master and register file.
module tb_mdio_slave;

    logic        clk;
    logic        rst;
    logic        mdc;
    logic        drv;
    logic        mdio_line;
    logic        mdio_o;
    logic        mdio_oe;
    logic [4:0]  phy_addr;
    logic [4:0]  reg_addr;
    logic        reg_rd;
    logic [15:0] reg_rdata;
    logic        reg_wr;
    logic [15:0] reg_wdata;
    logic        busy;
    logic        frame_err;

    logic [15:0] mem [32];

    typedef struct {
        bit          is_wr;
        logic [4:0]  addr;
        logic [15:0] data;
    } exp_t;

    exp_t        sb_q[$];
    logic [15:0] rd_q[$];

    int checks   = 0;
    int failures = 0;
    int err_cnt  = 0;
    bit oe_seen  = 1'b0;

    mdio_slave #(.PRE_MIN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .mdc_i     (mdc),
        .mdio_i    (mdio_line),
        .mdio_o    (mdio_o),
        .mdio_oe   (mdio_oe),
        .phy_addr  (phy_addr),
        .reg_addr  (reg_addr),
        .reg_rd    (reg_rd),
        .reg_rdata (reg_rdata),
        .reg_wr    (reg_wr),
        .reg_wdata (reg_wdata),
        .busy      (busy),
        .frame_err (frame_err)
    );

    // Open-drain style bus: slave wins while enabled, otherwise the master (pull-up when released).
    assign mdio_line = mdio_oe ? mdio_o : drv;
    assign reg_rdata = mem[reg_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One MDC period: master sets its bit during low phase, samples the line at the rising edge.
    task automatic send_bit(input logic b, output logic line, output logic oe);
        drv = b;
        tick(4);
        mdc  = 1'b1;
        line = mdio_line;
        oe   = mdio_oe;
        tick(4);
        mdc = 1'b0;
    endtask

    task automatic run_frame(input int npre, input logic [1:0] op, input logic [4:0] pa,
                             input logic [4:0] ra, input logic [15:0] wd,
                             input int nbits, input bit exp_ok);
        logic [31:0] fr;
        logic        line;
        logic        oe;
        logic [15:0] cap;
        bit          rd;
        exp_t        e;
        rd  = (op == 2'b10);
        cap = 16'd0;
        fr  = {2'b01, op, pa, ra, (rd ? 2'b11 : 2'b10), (rd ? 16'hFFFF : wd)};
        if (exp_ok) begin
            e.is_wr = !rd;
            e.addr  = ra;
            e.data  = wd;
            sb_q.push_back(e);
            if (rd && nbits == 32) rd_q.push_back(mem[ra]);
        end
        oe_seen = 1'b0;
        repeat (npre) send_bit(1'b1, line, oe);
        for (int k = 0; k < nbits; k++) begin
            send_bit(fr[31-k], line, oe);
            if (exp_ok && k == 8) chk("busy_mid", {31'd0, busy}, 32'd1);
            if (rd && exp_ok) begin
                if (k == 14) chk("ta_z", {31'd0, oe}, 32'd0);
                if (k == 15) chk("ta_zero", {30'd0, oe, line}, 32'd2);
                if (k >= 16) cap = {cap[14:0], line};
            end
        end
        drv = 1'b1;
        if (nbits == 32) begin
            tick(4);
            chk("oe_end", {31'd0, mdio_oe}, 32'd0);
            chk("busy_end", {31'd0, busy}, 32'd0);
            if (rd && exp_ok) chk("rd_data", {16'd0, cap}, {16'd0, rd_q.pop_front()});
            else chk("no_drive", {31'd0, oe_seen}, 32'd0);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_mdio_o"}, {31'd0, mdio_o}, 32'd1);
        chk({tag, "_mdio_oe"}, {31'd0, mdio_oe}, 32'd0);
        chk({tag, "_reg_rd"}, {31'd0, reg_rd}, 32'd0);
        chk({tag, "_reg_wr"}, {31'd0, reg_wr}, 32'd0);
        chk({tag, "_reg_addr"}, {27'd0, reg_addr}, 32'd0);
        chk({tag, "_reg_wdata"}, {16'd0, reg_wdata}, 32'd0);
        chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
        chk({tag, "_frame_err"}, {31'd0, frame_err}, 32'd0);
    endtask

    // Strobe monitor: pops the scoreboard on every register access, tracks drive and error pulses.
    always @(negedge clk) begin
        if (mdio_oe) oe_seen = 1'b1;
        if (frame_err) err_cnt++;
        if (reg_rd || reg_wr) begin
            exp_t e;
            chk("strobe_excl", {31'd0, reg_rd & reg_wr}, 32'd0);
            chk("strobe_expected", {31'd0, (sb_q.size() != 0)}, 32'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("strobe_kind", {31'd0, reg_wr}, {31'd0, e.is_wr});
                chk("strobe_addr", {27'd0, reg_addr}, {27'd0, e.addr});
                if (e.is_wr) chk("strobe_wdata", {16'd0, reg_wdata}, {16'd0, e.data});
            end
        end
    end

    initial begin
        int err_before;
        for (int i = 0; i < 32; i++) mem[i] = 16'(i * 257);
        mem[3]   = 16'hA5C3;
        mem[7]   = 16'h5A3C;
        rst      = 1'b1;
        mdc      = 1'b0;
        drv      = 1'b1;
        phy_addr = 5'd5;
        tick(4);
        chk_reset_vals("reset");
        rst = 1'b0;
        tick(4);

        // Basic read and write
        run_frame(32, 2'b10, 5'd5, 5'd3, 16'h0000, 32, 1'b1);
        run_frame(32, 2'b01, 5'd5, 5'h1F, 16'h1234, 32, 1'b1);

        // Address mismatch followed immediately by a matching read
        run_frame(32, 2'b10, 5'd6, 5'd3, 16'h0000, 32, 1'b0);
        run_frame(32, 2'b10, 5'd5, 5'd7, 16'h0000, 32, 1'b1);

        // Short preamble
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
        run_frame(20, 2'b01, 5'd5, 5'h0A, 16'hBEEF, 32, 1'b1);
`else
        run_frame(20, 2'b01, 5'd5, 5'h0A, 16'hBEEF, 32, 1'b0);
`endif

        // Malformed OP, then a valid write
        err_before = err_cnt;
        run_frame(32, 2'b11, 5'd5, 5'd3, 16'h0000, 4, 1'b0);
        tick(2);
        chk("bad_op_err", err_cnt, err_before + 1);
        chk("bad_op_busy", {31'd0, busy}, 32'd0);
        run_frame(32, 2'b01, 5'd5, 5'd9, 16'hC001, 32, 1'b1);

        // Reset in the middle of a read's data phase
        run_frame(32, 2'b10, 5'd5, 5'd3, 16'h0000, 21, 1'b1);
        chk("pre_rst_oe", {31'd0, mdio_oe}, 32'd1);
        rst = 1'b1;
        tick(1);
        chk_reset_vals("midrst");
        rst = 1'b0;
        tick(4);
        run_frame(32, 2'b10, 5'd5, 5'd3, 16'h0000, 32, 1'b1);

        tick(8);
        chk("sb_empty", sb_q.size(), 32'd0);
        chk("rdq_empty", rd_q.size(), 32'd0);
        chk("err_total", err_cnt, 32'd1);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
